// File: rtl/best_effect_selector.sv
// -----------------------------------------------------------------------------
// best_effect_selector
//
// Watches the one-hot step-enable bus from the pulse sequencer and counts error
// events for each enabled step. When the bus returns to zero, the counters are
// scanned one step per valid cycle, and the step with the fewest errors is
// reported together with its count.
//
// Build option:
//   BEST_EFFECT_SELECTOR_MAX_EN  defined   -> pick the largest count
//                                undefined -> pick the smallest count (default)
//
// Ports:
//   i_clock        single clock
//   i_reset        asynchronous, active-high reset
//   i_pulse_bus    one-hot step enable; all-zero means no step active
//   i_error        error event for the current cycle
//   i_valid        clock enable for all state and counter updates
//   o_best_sel     index of the winning step
//   o_best_count   error count of the winning step
//   o_partial      the last sweep did not visit every step
//   o_onehot_err   sticky: a multi-hot bus was seen during the current/last sweep
//   o_done         one-clock pulse: a new result is valid
//   o_busy         high while collecting or evaluating
//   o_step_counts  live counters, step k at [k*NB_COUNT +: NB_COUNT]
// -----------------------------------------------------------------------------
module best_effect_selector #(
  parameter int N_STEPS      = 5,
  parameter int LOG2_N_STEPS = 3,
  parameter int NB_COUNT     = 8
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [N_STEPS-1:0]           i_pulse_bus,
  input  logic                         i_error,
  input  logic                         i_valid,
  output logic [LOG2_N_STEPS-1:0]      o_best_sel,
  output logic [NB_COUNT-1:0]          o_best_count,
  output logic                         o_partial,
  output logic                         o_onehot_err,
  output logic                         o_done,
  output logic                         o_busy,
  output logic [N_STEPS*NB_COUNT-1:0]  o_step_counts
);

  // state      | meaning
  // ST_IDLE    | waiting for a rising edge of bus activity
  // ST_COLLECT | counting errors for the enabled step
  // ST_EVAL    | scanning the counters, one step per valid cycle
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EVAL    = 2'd2
  } state_t;

  localparam logic [LOG2_N_STEPS-1:0] LAST_STEP = LOG2_N_STEPS'(N_STEPS - 1);

  state_t                    state_q, state_d;
  logic [NB_COUNT-1:0]       cnt_q [N_STEPS];
  logic [NB_COUNT-1:0]       cnt_d [N_STEPS];
  logic [N_STEPS-1:0]        visited_q, visited_d;
  logic [LOG2_N_STEPS-1:0]   eval_q, eval_d;
  logic                      cand_vld_q, cand_vld_d;
  logic [LOG2_N_STEPS-1:0]   cand_idx_q, cand_idx_d;
  logic [NB_COUNT-1:0]       cand_cnt_q, cand_cnt_d;
  logic                      bus_prev_nz_q, bus_prev_nz_d;
  logic [LOG2_N_STEPS-1:0]   best_sel_q, best_sel_d;
  logic [NB_COUNT-1:0]       best_cnt_q, best_cnt_d;
  logic                      partial_q, partial_d;
  logic                      onehot_err_q, onehot_err_d;
  logic                      done_q, done_d;

  logic bus_nz;
  logic onehot;
  logic collect;
  logic better;

  assign bus_nz = |i_pulse_bus;
  // Clearing the lowest set bit leaves zero only for a single-bit bus.
  assign onehot = bus_nz && ((i_pulse_bus & (i_pulse_bus - 1'b1)) == '0);

`ifdef BEST_EFFECT_SELECTOR_MAX_EN
  assign better = cnt_q[eval_q] > cand_cnt_q;
`else
  assign better = cnt_q[eval_q] < cand_cnt_q;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    visited_d     = visited_q;
    eval_d        = eval_q;
    cand_vld_d    = cand_vld_q;
    cand_idx_d    = cand_idx_q;
    cand_cnt_d    = cand_cnt_q;
    bus_prev_nz_d = bus_prev_nz_q;
    best_sel_d    = best_sel_q;
    best_cnt_d    = best_cnt_q;
    partial_d     = partial_q;
    onehot_err_d  = onehot_err_q;
    done_d        = 1'b0;
    collect       = 1'b0;

    if (i_valid) begin
      bus_prev_nz_d = bus_nz;
      case (state_q)
        ST_IDLE: begin
          if (bus_nz && !bus_prev_nz_q) begin
            for (int k = 0; k < N_STEPS; k++) cnt_d[k] = '0;
            visited_d    = '0;
            onehot_err_d = 1'b0;
            collect      = 1'b1;
            state_d      = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (!bus_nz) begin
            state_d    = ST_EVAL;
            eval_d     = '0;
            cand_vld_d = 1'b0;
          end else begin
            collect = 1'b1;
          end
        end
        ST_EVAL: begin
          if (visited_q[eval_q] && (!cand_vld_q || better)) begin
            cand_vld_d = 1'b1;
            cand_idx_d = eval_q;
            cand_cnt_d = cnt_q[eval_q];
          end
          if (eval_q == LAST_STEP) begin
            // The final step's decision is folded straight into the result.
            best_sel_d = cand_idx_d;
            best_cnt_d = cand_cnt_d;
            partial_d  = ~&visited_q;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            eval_d = eval_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // The start cycle builds on the freshly cleared counters in cnt_d.
      if (collect) begin
        if (onehot) begin
          for (int k = 0; k < N_STEPS; k++) begin
            if (i_pulse_bus[k]) begin
              visited_d[k] = 1'b1;
              if (i_error && (cnt_d[k] != '1)) cnt_d[k] = cnt_d[k] + 1'b1;
            end
          end
        end else begin
          onehot_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      for (int k = 0; k < N_STEPS; k++) cnt_q[k] <= '0;
      visited_q     <= '0;
      eval_q        <= '0;
      cand_vld_q    <= 1'b0;
      cand_idx_q    <= '0;
      cand_cnt_q    <= '0;
      // Treat a bus that is already active at release as "not a new sweep".
      bus_prev_nz_q <= 1'b1;
      best_sel_q    <= '0;
      best_cnt_q    <= '0;
      partial_q     <= 1'b0;
      onehot_err_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      visited_q     <= visited_d;
      eval_q        <= eval_d;
      cand_vld_q    <= cand_vld_d;
      cand_idx_q    <= cand_idx_d;
      cand_cnt_q    <= cand_cnt_d;
      bus_prev_nz_q <= bus_prev_nz_d;
      best_sel_q    <= best_sel_d;
      best_cnt_q    <= best_cnt_d;
      partial_q     <= partial_d;
      onehot_err_q  <= onehot_err_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    o_step_counts = '0;
    for (int k = 0; k < N_STEPS; k++) o_step_counts[k*NB_COUNT +: NB_COUNT] = cnt_q[k];
  end

  assign o_best_sel   = best_sel_q;
  assign o_best_count = best_cnt_q;
  assign o_partial    = partial_q;
  assign o_onehot_err = onehot_err_q;
  assign o_done       = done_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_best_effect_selector.sv
// -----------------------------------------------------------------------------
// tb_best_effect_selector
//
// Directed bench for best_effect_selector with hand-computed expectations.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// Expectations follow BEST_EFFECT_SELECTOR_MAX_EN when it is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_best_effect_selector;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [4:0]  i_pulse_bus = '0;
  logic        i_error = 1'b0;
  logic        i_valid = 1'b0;
  logic [2:0]  o_best_sel;
  logic [7:0]  o_best_count;
  logic        o_partial;
  logic        o_onehot_err;
  logic        o_done;
  logic        o_busy;
  logic [39:0] o_step_counts;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done_seen;

  always #5 i_clock = ~i_clock;

  best_effect_selector #(.N_STEPS(5), .LOG2_N_STEPS(3), .NB_COUNT(8)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_pulse_bus   (i_pulse_bus),
    .i_error       (i_error),
    .i_valid       (i_valid),
    .o_best_sel    (o_best_sel),
    .o_best_count  (o_best_count),
    .o_partial     (o_partial),
    .o_onehot_err  (o_onehot_err),
    .o_done        (o_done),
    .o_busy        (o_busy),
    .o_step_counts (o_step_counts)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one rising edge; return at the next falling edge.
  task automatic cyc(input logic [4:0] bus, input logic err, input logic vld);
    i_pulse_bus = bus;
    i_error     = err;
    i_valid     = vld;
    @(negedge i_clock);
    if (o_done) n_done_seen++;
  endtask

  // nerr error cycles followed by one quiet cycle on step k.
  task automatic send_step(input int k, input int nerr);
    logic [4:0] b;
    b = 5'b00001 << k;
    for (int i = 0; i < nerr; i++) cyc(b, 1'b1, 1'b1);
    cyc(b, 1'b0, 1'b1);
  endtask

  // Drop the bus, wait for o_done with continuous valid and check the result.
  task automatic finish(input string tag, input logic [2:0] sel, input logic [7:0] cnt,
                        input logic part);
    int n;
    cyc(5'b0, 1'b0, 1'b1);
    n = 0;
    while (!o_done && n < 30) begin
      cyc(5'b0, 1'b1, 1'b1);
      n++;
    end
    check({tag, "_latency"}, n, 5);
    check({tag, "_sel"}, o_best_sel, sel);
    check({tag, "_cnt"}, o_best_count, cnt);
    check({tag, "_partial"}, o_partial, part);
    cyc(5'b0, 1'b0, 1'b1);
    check({tag, "_done_pulse"}, o_done, 1'b0);
    check({tag, "_idle"}, o_busy, 1'b0);
  endtask

  initial begin
    int n;
    n_done_seen = 0;
    @(negedge i_clock);
    check("rst_sel", o_best_sel, 3'd0);
    check("rst_cnt", o_best_count, 8'd0);
    check("rst_counts", o_step_counts, 40'h0);
    check("rst_flags", {o_partial, o_onehot_err, o_done, o_busy}, 4'b0);
    i_reset = 1'b0;
    cyc(5'b0, 1'b0, 1'b1);
    cyc(5'b0, 1'b0, 1'b1);

    // 1: full sweep 3,1,4,1,5
    send_step(0, 3);
    check("t1_busy", o_busy, 1'b1);
    send_step(1, 1);
    send_step(2, 4);
    send_step(3, 1);
    send_step(4, 5);
    check("t1_counts", o_step_counts, 40'h05_01_04_01_03);
`ifdef BEST_EFFECT_SELECTOR_MAX_EN
    finish("t1", 3'd4, 8'd5, 1'b0);
`else
    finish("t1", 3'd1, 8'd1, 1'b0);
`endif
    check("t1_onehot_err", o_onehot_err, 1'b0);

    // 2: saturation on step 2
    for (int i = 0; i < 300; i++) cyc(5'b00100, 1'b1, 1'b1);
    check("t2_sat", o_step_counts[23:16], 8'hFF);
    check("t2_cleared0", o_step_counts[7:0], 8'h00);
    finish("t2", 3'd2, 8'hFF, 1'b1);

    // 3: partial sweep
    send_step(0, 2);
    send_step(1, 7);
`ifdef BEST_EFFECT_SELECTOR_MAX_EN
    finish("t3", 3'd1, 8'd7, 1'b1);
`else
    finish("t3", 3'd0, 8'd2, 1'b1);
`endif

    // 4: multi-hot mid-sweep, valid toggled; invalid cycles carry errors
    begin
      logic [4:0] seq_bus [8];
      logic       seq_err [8];
      seq_bus = '{5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b00100, 5'b00110, 5'b01000, 5'b10000};
      seq_err = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      // per-entry repeat counts: step0 2, step1 3, step2 1, multi 3, step3 4, step4 2
      for (int e = 0; e < 8; e++) begin
        int reps;
        case (e)
          0: reps = 2; 1: reps = 0; 2: reps = 3; 3: reps = 0;
          4: reps = 1; 5: reps = 3; 6: reps = 4; default: reps = 2;
        endcase
        for (int r = 0; r < reps; r++) begin
          cyc(seq_bus[e], seq_err[e], 1'b1);
          cyc(seq_bus[e], 1'b1, 1'b0);
        end
      end
    end
    check("t4_onehot_err", o_onehot_err, 1'b1);
    check("t4_counts", o_step_counts, 40'h02_04_01_03_02);
    n = 0;
    while (!o_done && n < 40) begin
      cyc(5'b0, 1'b1, n[0] ? 1'b0 : 1'b1);
      n++;
    end
    check("t4_done_seen", o_done, 1'b1);
`ifdef BEST_EFFECT_SELECTOR_MAX_EN
    check("t4_sel", o_best_sel, 3'd3);
    check("t4_cnt", o_best_count, 8'd4);
`else
    check("t4_sel", o_best_sel, 3'd2);
    check("t4_cnt", o_best_count, 8'd1);
`endif
    check("t4_partial", o_partial, 1'b0);
    cyc(5'b0, 1'b0, 1'b0);
    check("t4_err_held", o_onehot_err, 1'b1);
    cyc(5'b0, 1'b0, 1'b1);

    // 5: bus activity during evaluation
    cyc(5'b00001, 1'b1, 1'b1);
    check("t5_err_cleared", o_onehot_err, 1'b0);
    cyc(5'b00010, 1'b1, 1'b1);
    cyc(5'b00010, 1'b1, 1'b1);
    cyc(5'b0, 1'b0, 1'b1);
    n = 0;
    while (!o_done && n < 30) begin
      cyc(5'b00001, 1'b1, 1'b1);
      n++;
    end
    check("t5_latency", n, 5);
`ifdef BEST_EFFECT_SELECTOR_MAX_EN
    check("t5_sel", o_best_sel, 3'd1);
    check("t5_cnt", o_best_count, 8'd2);
`else
    check("t5_sel", o_best_sel, 3'd0);
    check("t5_cnt", o_best_count, 8'd1);
`endif
    n_done_seen = 0;
    for (int i = 0; i < 10; i++) cyc(5'b00001, 1'b1, 1'b1);
    check("t5_no_second_done", n_done_seen, 0);
    check("t5_no_start", o_busy, 1'b0);
    check("t5_frozen", o_step_counts[15:0], 16'h0201);
    cyc(5'b0, 1'b0, 1'b1);
    cyc(5'b00001, 1'b0, 1'b1);
    check("t5_restart", o_busy, 1'b1);
    check("t5_restart_clear", o_step_counts, 40'h0);

    // 6: async reset mid-collect
    cyc(5'b00100, 1'b1, 1'b1);
    cyc(5'b00100, 1'b1, 1'b1);
    check("t6_pre_counts", o_step_counts[23:16], 8'd2);
    #1 i_reset = 1'b1;
    #1;
    check("t6_rst_busy", o_busy, 1'b0);
    check("t6_rst_counts", o_step_counts, 40'h0);
    check("t6_rst_result", {o_best_sel, o_best_count, o_partial, o_onehot_err, o_done}, 14'h0);
    @(negedge i_clock);
    i_reset = 1'b0;
    n_done_seen = 0;
    for (int i = 0; i < 5; i++) cyc(5'b00100, 1'b1, 1'b1);
    check("t6_no_start", o_busy, 1'b0);
    check("t6_no_count", o_step_counts, 40'h0);
    check("t6_no_done", n_done_seen, 0);
    cyc(5'b0, 1'b0, 1'b1);
    send_step(0, 3);
    check("t6_started", o_busy, 1'b1);
    send_step(1, 1);
    send_step(2, 4);
    send_step(3, 1);
    send_step(4, 5);
`ifdef BEST_EFFECT_SELECTOR_MAX_EN
    finish("t6", 3'd4, 8'd5, 1'b0);
`else
    finish("t6", 3'd1, 8'd1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
